mem_bus_arbiter: RTL and testbench



---
 rtl/mem_bus_arbiter_pkg.sv | 22 ++
 rtl/mem_addr_decode.sv | 25 ++
 rtl/mem_bus_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants for the CPU memory-bus arbiter: region patterns, FSM
// state encodings, grant encodings and the decode result record.
package mem_bus_arbiter_pkg;

  localparam logic [20:0] ROM_HI       = 21'h0;
  localparam logic [31:0] RAM_BASE_DEF = 32'h1000_0000;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic GNT_FETCH = 1'b0;
  localparam logic GNT_DATA  = 1'b1;

  typedef struct packed {
    logic       is_rom;
    logic       is_ram;
    logic       fault;
    logic [8:0] word_idx;
  } dec_t;

endpackage

// File: rtl/mem_addr_decode.sv
// Region decode for one bus address: ROM/RAM hit, fault and word index.
module mem_addr_decode
  import mem_bus_arbiter_pkg::*;
#(
  parameter logic [31:0] RAM_BASE = RAM_BASE_DEF
) (
  input  logic [31:0] addr,
  input  logic        we,
  output dec_t        dec
);

  logic rom_hit;
  logic ram_hit;

  always_comb begin
    rom_hit      = (addr[31:11] == ROM_HI);
    ram_hit      = (addr[31:11] == RAM_BASE[31:11]) && !rom_hit;
    dec.is_rom   = rom_hit;
    dec.is_ram   = ram_hit;
    // ROM is read-only; misaligned or unmapped addresses never reach a memory
    dec.fault    = !(rom_hit || ram_hit) || (addr[1:0] != 2'b00) || (rom_hit && we);
    dec.word_idx = addr[10:2];
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing instruction ROM and data RAM between the
// fetch and data ports, with per-region wait states and registered outputs.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ROM_WS   = 1,
  parameter int unsigned RAM_WS   = 1,
  parameter logic [31:0] RAM_BASE = RAM_BASE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic        if_err,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic        rom_nce,
  output logic        rom_re,
  output logic [8:0]  rom_addr,
  input  logic [31:0] rom_dout,
  output logic        ram_nce,
  output logic        ram_re,
  output logic        ram_we,
  output logic [8:0]  ram_addr,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout,
  output logic        busy
);

  localparam logic [3:0] ROM_WS_C = 4'(ROM_WS);
  localparam logic [3:0] RAM_WS_C = 4'(RAM_WS);

  logic [1:0]  state, state_n;
  logic        last_grant;
  logic        grant;
  logic        tgt_rom;
  logic        acc_we;
  logic [3:0]  wait_cnt;

  logic        any_req;
  logic        contested;
  logic        pick_data;
  logic [31:0] sel_addr;
  logic        sel_we;
  logic [31:0] rd_src;
  dec_t        dec;

  always_comb begin
    any_req   = if_req | d_req;
    contested = if_req & d_req;
    // on a tie the port that did not win the previous tie goes first
    pick_data = d_req & (~if_req | (last_grant == GNT_FETCH));
    sel_addr  = pick_data ? d_addr : if_addr;
    sel_we    = pick_data & d_we;
    rd_src    = tgt_rom ? rom_dout : ram_dout;
  end

  mem_addr_decode #(.RAM_BASE(RAM_BASE)) u_dec (
    .addr (sel_addr),
    .we   (sel_we),
    .dec  (dec)
  );

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:   if (any_req) state_n = dec.fault ? ST_DONE : ST_ACCESS;
      ST_ACCESS: if (wait_cnt == 4'd0) state_n = ST_DONE;
      ST_DONE:   state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      last_grant <= GNT_DATA;
      grant      <= GNT_FETCH;
      tgt_rom    <= 1'b0;
      acc_we     <= 1'b0;
      wait_cnt   <= 4'd0;
      rom_nce    <= 1'b1;
      rom_re     <= 1'b0;
      rom_addr   <= 9'd0;
      ram_nce    <= 1'b1;
      ram_re     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= 9'd0;
      ram_din    <= 32'd0;
      if_ack     <= 1'b0;
      if_err     <= 1'b0;
      if_rdata   <= 32'd0;
      d_ack      <= 1'b0;
      d_err      <= 1'b0;
      d_rdata    <= 32'd0;
    end else begin
      state  <= state_n;
      busy   <= (state_n != ST_IDLE);
      if_ack <= 1'b0;
      if_err <= 1'b0;
      d_ack  <= 1'b0;
      d_err  <= 1'b0;
      case (state)
        ST_IDLE: if (any_req) begin
          grant   <= pick_data;
          acc_we  <= sel_we;
          tgt_rom <= dec.is_rom;
          if (contested) last_grant <= pick_data;
          if (dec.fault) begin
            // faulted access: straight to DONE, memories never selected
            if (pick_data) begin
              d_ack <= 1'b1;
              d_err <= 1'b1;
            end else begin
              if_ack <= 1'b1;
              if_err <= 1'b1;
            end
          end else begin
            wait_cnt <= dec.is_rom ? ROM_WS_C : RAM_WS_C;
            rom_nce  <= ~dec.is_rom;
            rom_re   <= dec.is_rom;
            ram_nce  <= ~dec.is_ram;
            ram_re   <= dec.is_ram & ~sel_we;
            ram_we   <= dec.is_ram & sel_we;
            if (dec.is_rom) rom_addr <= dec.word_idx;
            if (dec.is_ram) ram_addr <= dec.word_idx;
            if (dec.is_ram && sel_we) ram_din <= d_wdata;
          end
        end
        ST_ACCESS: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            rom_nce <= 1'b1;
            rom_re  <= 1'b0;
            ram_nce <= 1'b1;
            ram_re  <= 1'b0;
            ram_we  <= 1'b0;
            if (grant == GNT_DATA) begin
              d_ack <= 1'b1;
              if (!acc_we) d_rdata <= rd_src;
            end else begin
              if_ack   <= 1'b1;
              if_rdata <= rd_src;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed plus randomized bench for mem_bus_arbiter with a spec-level
// reference model (region rules, latency formula, shadow RAM, tie tracking).
module tb_mem_bus_arbiter;

  localparam int unsigned ROM_WS   = 1;
  localparam int unsigned RAM_WS   = 0;
  localparam logic [31:0] RAM_BASE = 32'h1000_0000;
  localparam logic [20:0] RAM_HI   = RAM_BASE[31:11];
  localparam logic [31:0] IDLE_BUS = 32'hBAD0_BAD0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main DUT
  logic        rst, if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic        if_ack, if_err, d_ack, d_err, busy;
  logic [31:0] if_rdata, d_rdata, rom_dout, ram_dout, ram_din;
  logic        rom_nce, rom_re, ram_nce, ram_re, ram_we;
  logic [8:0]  rom_addr, ram_addr;

  // second DUT with ROM_WS=3 for the mid-access reset case
  logic        rst2, if_req2, d_req2, d_we2;
  logic [31:0] if_addr2, d_addr2, d_wdata2;
  logic        if_ack2, if_err2, d_ack2, d_err2, busy2;
  logic [31:0] if_rdata2, d_rdata2, rom_dout2, ram_dout2, ram_din2;
  logic        rom_nce2, rom_re2, ram_nce2, ram_re2, ram_we2;
  logic [8:0]  rom_addr2, ram_addr2;

  mem_bus_arbiter #(.ROM_WS(ROM_WS), .RAM_WS(RAM_WS), .RAM_BASE(RAM_BASE)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_err(if_err), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .rom_nce(rom_nce), .rom_re(rom_re), .rom_addr(rom_addr), .rom_dout(rom_dout),
    .ram_nce(ram_nce), .ram_re(ram_re), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout), .busy(busy)
  );

  mem_bus_arbiter #(.ROM_WS(3), .RAM_WS(1), .RAM_BASE(RAM_BASE)) dut2 (
    .clk(clk), .rst(rst2),
    .if_req(if_req2), .if_addr(if_addr2), .if_ack(if_ack2), .if_err(if_err2), .if_rdata(if_rdata2),
    .d_req(d_req2), .d_we(d_we2), .d_addr(d_addr2), .d_wdata(d_wdata2),
    .d_ack(d_ack2), .d_err(d_err2), .d_rdata(d_rdata2),
    .rom_nce(rom_nce2), .rom_re(rom_re2), .rom_addr(rom_addr2), .rom_dout(rom_dout2),
    .ram_nce(ram_nce2), .ram_re(ram_re2), .ram_we(ram_we2), .ram_addr(ram_addr2),
    .ram_din(ram_din2), .ram_dout(ram_dout2), .busy(busy2)
  );

  function automatic logic [31:0] rom_word(input logic [8:0] i);
    return {16'hC0DE, 7'd0, i} ^ {i, 23'd0};
  endfunction

  function automatic logic [31:0] ram_init(input logic [8:0] i);
    return {16'h7A70, 7'd0, i};
  endfunction

  // memory models: bus reads garbage whenever the chip is deselected
  logic [31:0] ram_mem [512];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 512; i++) ram_mem[i] <= ram_init(9'(i));
    end else if (!ram_nce && ram_we) begin
      ram_mem[ram_addr] <= ram_din;
    end
  end
  assign rom_dout  = !rom_nce  ? rom_word(rom_addr)  : IDLE_BUS;
  assign ram_dout  = !ram_nce  ? ram_mem[ram_addr]   : IDLE_BUS;
  assign rom_dout2 = !rom_nce2 ? rom_word(rom_addr2) : IDLE_BUS;
  assign ram_dout2 = IDLE_BUS;

  // reference state
  int          total = 0;
  int          bad   = 0;
  logic [31:0] ref_ram [512];
  logic [31:0] exp_if_rdata, exp_d_rdata;
  bit          last_tie;   // 0 = fetch won the last contested grant, 1 = data

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // single-port transaction, called at a negedge with the DUT idle
  task automatic access(input string nm, input bit pd, input bit we,
                        input logic [31:0] addr, input logic [31:0] wdata);
    bit rom_hit, ram_hit, fault, wr, got;
    int ws, lat, rom_n, ram_n, bad_strobe, stray;
    logic [8:0]  idx;
    logic [31:0] obs_err, obs_rd;
    rom_hit = (addr[31:11] == 21'd0);
    ram_hit = (addr[31:11] == RAM_HI);
    wr      = pd && we;
    fault   = !(rom_hit || ram_hit) || (addr[1:0] != 2'b00) || (wr && rom_hit);
    ws      = rom_hit ? int'(ROM_WS) : int'(RAM_WS);
    idx     = addr[10:2];
    got = 0; lat = 0; rom_n = 0; ram_n = 0; bad_strobe = 0; stray = 0;
    if (pd) begin
      d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      if_req = 1; if_addr = addr; d_we = we;   // d_we must not matter for fetch
    end
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      if (!rom_nce) begin
        rom_n++;
        if (rom_addr !== idx || rom_re !== 1'b1) bad_strobe++;
      end
      if (!ram_nce) begin
        ram_n++;
        if (ram_addr !== idx || ram_re !== !wr || ram_we !== wr || (wr && ram_din !== wdata))
          bad_strobe++;
      end
      if (pd ? if_ack : d_ack) stray++;
      if (pd ? d_ack : if_ack) begin got = 1; lat = c; end
    end
    obs_err = {31'd0, pd ? d_err : if_err};
    obs_rd  = pd ? d_rdata : if_rdata;
    if (!fault && !wr) begin
      if (pd) exp_d_rdata  = rom_hit ? rom_word(idx) : ref_ram[idx];
      else    exp_if_rdata = rom_hit ? rom_word(idx) : ref_ram[idx];
    end
    if (!fault && wr) ref_ram[idx] = wdata;
    chk({nm, ":ack"},    32'(got), 32'd1);
    chk({nm, ":lat"},    lat, fault ? 1 : ws + 2);
    chk({nm, ":err"},    obs_err, {31'd0, fault});
    chk({nm, ":rdata"},  obs_rd, pd ? exp_d_rdata : exp_if_rdata);
    chk({nm, ":rom_cs"}, rom_n, (!fault && rom_hit) ? ws + 1 : 0);
    chk({nm, ":ram_cs"}, ram_n, (!fault && ram_hit) ? ws + 1 : 0);
    chk({nm, ":strobe"}, bad_strobe, 0);
    chk({nm, ":stray"},  stray, 0);
    if (pd) d_req = 0; else if_req = 0;
    @(negedge clk);
    chk({nm, ":idle"}, {29'd0, if_ack, d_ack, busy}, 32'd0);
  endtask

  // both ports raise together; winner follows the tie history
  task automatic tie_pair(input string nm);
    int order[$];
    bit winner;
    winner = !last_tie;
    if_req = 1; if_addr = 32'h0000_0004;
    d_req  = 1; d_we = 0; d_addr = RAM_BASE + 32'h8;
    for (int c = 0; c < 40 && order.size() < 2; c++) begin
      @(negedge clk);
      if (if_ack) begin
        order.push_back(0); if_req = 0; exp_if_rdata = rom_word(9'd1);
        chk({nm, ":f_rd"}, if_rdata, exp_if_rdata);
      end
      if (d_ack) begin
        order.push_back(1); d_req = 0; exp_d_rdata = ref_ram[2];
        chk({nm, ":d_rd"}, d_rdata, exp_d_rdata);
      end
    end
    chk({nm, ":count"}, order.size(), 2);
    if (order.size() == 2) begin
      chk({nm, ":first"},  order[0], int'(winner));
      chk({nm, ":second"}, order[1], int'(!winner));
    end
    last_tie = winner;
    if_req = 0; d_req = 0;
    @(negedge clk);
  endtask

  initial begin
    int order[$];
    int f_gap, d_gap, cyc, seen;
    for (int i = 0; i < 512; i++) ref_ram[i] = ram_init(9'(i));
    exp_if_rdata = 32'd0; exp_d_rdata = 32'd0;
    last_tie = 1'b1;
    rst = 1; rst2 = 1;
    if_req = 1; if_addr = 32'h0; d_req = 1; d_we = 0; d_addr = 32'h1000_0004; d_wdata = 32'd0;
    if_req2 = 0; if_addr2 = 32'd0; d_req2 = 0; d_we2 = 0; d_addr2 = 32'd0; d_wdata2 = 32'd0;

    // reset with both requests pending
    repeat (3) @(negedge clk);
    chk("rst:nce",   {30'd0, rom_nce, ram_nce}, 32'd3);
    chk("rst:strb",  {29'd0, rom_re, ram_re, ram_we}, 32'd0);
    chk("rst:ack",   {28'd0, if_ack, if_err, d_ack, d_err}, 32'd0);
    chk("rst:busy",  {31'd0, busy}, 32'd0);
    chk("rst:rdata", if_rdata | d_rdata, 32'd0);
    rst = 0; rst2 = 0;

    // continuous contention: grants alternate F, D, F, D
    f_gap = 0; d_gap = 0; cyc = 0;
    while (cyc < 80 && !(order.size() >= 4 && !if_req && !d_req && !busy)) begin
      @(negedge clk); cyc++;
      if (cyc == 1) begin
        chk("alt:first_grant", {30'd0, rom_nce, ram_nce}, 32'd1);
        last_tie = 1'b0;
      end
      chk("alt:one_ack", {31'd0, if_ack & d_ack}, 32'd0);
      if (if_ack) begin
        order.push_back(0);
        chk("alt:f_err", {31'd0, if_err}, 32'd0);
        chk("alt:f_rd",  if_rdata, rom_word(9'd0));
      end
      if (d_ack) begin
        order.push_back(1);
        chk("alt:d_err", {31'd0, d_err}, 32'd0);
        chk("alt:d_rd",  d_rdata, ref_ram[1]);
      end
      if (if_ack) begin if_req = 0; f_gap = 1; end
      else if (f_gap != 0) f_gap = 0;
      else if (order.size() < 4) if_req = 1;
      if (d_ack) begin d_req = 0; d_gap = 1; end
      else if (d_gap != 0) d_gap = 0;
      else if (order.size() < 4) d_req = 1;
    end
    chk("alt:timeout", 32'(cyc < 80), 32'd1);
    chk("alt:n", 32'(order.size() >= 4), 32'd1);
    if (order.size() >= 4) begin
      chk("alt:o0", order[0], 0);
      chk("alt:o1", order[1], 1);
      chk("alt:o2", order[2], 0);
      chk("alt:o3", order[3], 1);
    end
    exp_if_rdata = rom_word(9'd0);
    exp_d_rdata  = ref_ram[1];

    tie_pair("tie1");
    tie_pair("tie2");

    // directed transactions
    access("fetch8", 0, 0, 32'h0000_0008, 32'd0);
    access("dwr",    1, 1, 32'h1000_0010, 32'hDEAD_BEEF);
    access("drd",    1, 0, 32'h1000_0010, 32'd0);
    access("f_ram",  0, 1, 32'h1000_0010, 32'd0);
    access("flt_wr_rom", 1, 1, 32'h0000_0004, 32'h1234_5678);
    access("flt_misal",  1, 0, 32'h1000_0002, 32'd0);
    access("flt_region", 0, 0, 32'h2000_0000, 32'd0);
    access("rom_top",    1, 0, 32'h0000_07FC, 32'd0);
    access("ram_top",    1, 1, 32'h1000_07FC, 32'hA5A5_5A5A);

    // randomized mix
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      logic [8:0]  ix;
      int          k;
      bit          pd, we;
      ix = 9'($urandom_range(0, 511));
      k  = int'($urandom_range(0, 7));
      pd = 1'($urandom);
      we = 1'($urandom);
      case (k)
        0, 1, 2: a = {21'd0, ix, 2'b00};
        3, 4, 5: a = {RAM_HI, ix, 2'b00};
        6:       a = {(pd ? RAM_HI : 21'd0), ix, 2'($urandom_range(1, 3))};
        default: a = {3'b111, 29'($urandom)};
      endcase
      access("rnd", pd, we, a, $urandom);
    end

    // reset during the second ACCESS cycle of a ROM_WS=3 fetch
    @(negedge clk);
    if_req2 = 1; if_addr2 = 32'h0000_000C;
    @(negedge clk);
    chk("rst2:c1_sel", {31'd0, rom_nce2}, 32'd0);
    @(negedge clk);
    chk("rst2:c2_sel", {31'd0, rom_nce2}, 32'd0);
    #1 rst2 = 1;
    #1;
    chk("rst2:nce", {31'd0, rom_nce2}, 32'd1);
    chk("rst2:re",  {31'd0, rom_re2}, 32'd0);
    chk("rst2:busy", {31'd0, busy2}, 32'd0);
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (if_ack2) seen++;
    end
    chk("rst2:no_ack", seen, 0);
    rst2 = 0;
    begin
      int lat, strobes;
      bit got;
      lat = 0; strobes = 0; got = 0;
      for (int c = 1; c <= 30 && !got; c++) begin
        @(negedge clk);
        if (!rom_nce2) strobes++;
        if (if_ack2) begin got = 1; lat = c; end
      end
      chk("rst2:ack",    32'(got), 32'd1);
      chk("rst2:lat",    lat, 5);
      chk("rst2:strobe", strobes, 4);
      chk("rst2:err",    {31'd0, if_err2}, 32'd0);
      chk("rst2:rdata",  if_rdata2, rom_word(9'd3));
    end
    if_req2 = 0;
    @(negedge clk);
    chk("rst2:d_side", {26'd0, d_ack2, d_err2, ram_re2, ram_we2, busy2, !ram_nce2}, 32'd0);
    chk("rst2:d_bus",  d_rdata2 | ram_din2 | {23'd0, ram_addr2}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
